// File: rtl/circular_history_buffer.sv
// -----------------------------------------------------------------------------
// circular_history_buffer
//
// Purpose:
//   Keeps the most recent DEPTH samples of a stream in a circular array and
//   serves random reads indexed relative to either the oldest or the newest
//   stored sample. Occupancy is tracked so that reads beyond the stored range
//   are flagged as out-of-bounds and return 0 instead of stale data.
//
// Parameters:
//   DATA_W  sample width in bits
//   DEPTH   number of stored samples (2 .. 2**ADDR_W, any integer)
//   ADDR_W  pointer / relative-index width, 2**ADDR_W >= DEPTH
//
// Ports:
//   clk             single clock, rising edge
//   rst_n           synchronous reset, active-low
//   wr_en, wr_data  write strobe and sample, one sample per asserted cycle
//   rd_en           read request
//   rd_rel          relative index of the sample to read
//   rd_from_newest  0 = index from oldest, 1 = index from newest
//   freeze          capture hold (only when CHB_FREEZE_EN is defined)
//   rd_data         read sample, 0 when rd_oob
//   rd_valid        one-cycle pulse, rd_data/rd_oob valid
//   rd_oob          requested index was outside the stored range
//   wr_ptr          physical address of the next write
//   oldest_ptr      physical address of the oldest stored sample
//   count           number of stored samples, 0..DEPTH
//   full            count == DEPTH
//
// Optional feature macro: CHB_FREEZE_EN
//   When defined, a freeze input holds the stored history (writes ignored)
//   while reads continue to operate on the frozen contents.
// -----------------------------------------------------------------------------
module circular_history_buffer #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 800,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_rel,
    input  logic              rd_from_newest,
`ifdef CHB_FREEZE_EN
    input  logic              freeze,
`endif
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_oob,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] oldest_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] r_wrPtr;
    logic [ADDR_W-1:0] r_oldestPtr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic [DATA_W-1:0] r_rdData;
    logic              r_rdValid;
    logic              r_rdOob;

    logic              w_wrAccept;
    logic [ADDR_W:0]   w_oldSum;
    logic [ADDR_W:0]   w_newDiff;
    logic [ADDR_W:0]   w_rdAddr;
    logic              w_rdOob;
    logic [ADDR_W-1:0] w_wrPtrNext;
    logic [ADDR_W-1:0] w_oldestPtrNext;

`ifdef CHB_FREEZE_EN
    assign w_wrAccept = wr_en & ~freeze;
`else
    assign w_wrAccept = wr_en;
`endif

    assign w_wrPtrNext     = (r_wrPtr == LAST_ADDR) ? '0 : r_wrPtr + ADDR_W'(1);
    assign w_oldestPtrNext = (r_oldestPtr == LAST_ADDR) ? '0 : r_oldestPtr + ADDR_W'(1);

    // Out-of-range when the index reaches past the stored samples; this also
    // covers an empty buffer and any index >= DEPTH.
    assign w_rdOob = ({1'b0, rd_rel} >= r_count);

    // Physical read address. One extra bit of headroom lets a single
    // conditional correction fold the sum/difference back into 0..DEPTH-1.
    // In newest mode the top bit of the difference acts as the sign bit,
    // which is exact because both operands are below 2**ADDR_W.
    always_comb begin
        w_oldSum  = {1'b0, r_oldestPtr} + {1'b0, rd_rel};
        w_newDiff = {1'b0, r_wrPtr} - (ADDR_W+1)'(1) - {1'b0, rd_rel};
        w_rdAddr  = '0;
        if (rd_from_newest) begin
            if (w_newDiff[ADDR_W]) begin
                w_rdAddr = w_newDiff + DEPTH_EXT;
            end else begin
                w_rdAddr = w_newDiff;
            end
        end else begin
            if (w_oldSum >= DEPTH_EXT) begin
                w_rdAddr = w_oldSum - DEPTH_EXT;
            end else begin
                w_rdAddr = w_oldSum;
            end
        end
    end

    // Sample storage is deliberately left uncleared by reset; validity is
    // defined purely by the occupancy count.
    always_ff @(posedge clk) begin
        if (rst_n && w_wrAccept) begin
            r_mem[r_wrPtr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking. Once full, each write overwrites the
    // oldest sample, so the oldest pointer advances alongside the write one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr     <= '0;
            r_oldestPtr <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
        end else if (w_wrAccept) begin
            r_wrPtr <= w_wrPtrNext;
            if (r_count == DEPTH_EXT) begin
                r_oldestPtr <= w_oldestPtrNext;
            end else begin
                r_count <= r_count + (ADDR_W+1)'(1);
                r_full  <= (r_count == DEPTH_EXT - (ADDR_W+1)'(1));
            end
        end
    end

    // Registered read port. It samples the pre-write state, giving
    // read-before-write behaviour when a read and a write share a cycle.
    // Data and oob hold between requests; only the valid strobe drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdData  <= '0;
            r_rdValid <= 1'b0;
            r_rdOob   <= 1'b0;
        end else if (rd_en) begin
            r_rdValid <= 1'b1;
            r_rdOob   <= w_rdOob;
            r_rdData  <= w_rdOob ? '0 : r_mem[w_rdAddr[ADDR_W-1:0]];
        end else begin
            r_rdValid <= 1'b0;
        end
    end

    assign rd_data    = r_rdData;
    assign rd_valid   = r_rdValid;
    assign rd_oob     = r_rdOob;
    assign wr_ptr     = r_wrPtr;
    assign oldest_ptr = r_oldestPtr;
    assign count      = r_count;
    assign full       = r_full;

endmodule

// File: doc/circular_history_buffer.md
# circular_history_buffer

Single-clock, parametrised circular sample-history buffer for the DSP datapath. It stores the most recent DEPTH samples of a stream and serves random reads indexed relative to either the oldest or the newest stored sample. Occupancy tracking reports out-of-range reads instead of returning stale data. It sits between the ADC sample stream and the display/processing stages.

## Interface
- DATA_W, 12: sample width in bits.
- DEPTH, 800: number of stored samples; any integer from 2 to 2^ADDR_W, power of two not required.
- ADDR_W, 10: pointer and relative-index width; must satisfy 2^ADDR_W >= DEPTH.

- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- wr_en  in  1  write strobe; one sample accepted per asserted cycle.
- wr_data  in  DATA_W  sample to store.
- rd_en  in  1  read request.
- rd_rel  in  ADDR_W  relative index of the sample to read.
- rd_from_newest  in  1  read mode: 0 = index from oldest, 1 = index from newest.
- freeze  in  1  capture hold; present only with CHB_FREEZE_EN.
- rd_data  out  DATA_W  read sample; 0 when rd_oob.
- rd_valid  out  1  rd_data/rd_oob valid this cycle.
- rd_oob  out  1  the requested index was not within the stored range.
- wr_ptr  out  ADDR_W  physical address of the next write.
- oldest_ptr  out  ADDR_W  physical address of the oldest stored sample.
- count  out  ADDR_W+1  number of stored samples, 0..DEPTH.
- full  out  1  count == DEPTH.

## Operation
- Storage: DEPTH x DATA_W array. Contents are not cleared by reset; occupancy alone defines validity.
- Accepted write: mem[wr_ptr] <= wr_data. Then wr_ptr <= (wr_ptr == DEPTH-1) ? 0 : wr_ptr+1.
- If count < DEPTH on an accepted write, count increments.
- If count == DEPTH on an accepted write, count holds and oldest_ptr advances with the same modulo wrap. The oldest sample is overwritten.
- Read address computation uses ADDR_W+1-bit intermediates with a single conditional correction:
  - oldest mode: a = oldest_ptr + rd_rel; if a >= DEPTH then a -= DEPTH.
  - newest mode: a = wr_ptr - 1 - rd_rel; if the result is negative then a += DEPTH.
- rd_oob = (rd_rel >= count). This includes count == 0 and any rd_rel >= DEPTH. When rd_oob is set, the array is not read for the result and rd_data = 0.
- Read and write in the same cycle: the read uses the pointers, count and array contents from before that write (read-before-write).

## Timing
- Reset (rst_n low at a clock edge): wr_ptr, oldest_ptr, count, full, rd_data, rd_valid and rd_oob all go to 0.
- Reset takes priority over wr_en/rd_en in the same cycle. Reset mid-stream discards history immediately; the next accepted write lands at address 0.
- Write latency: count, full and pointers update on the edge that samples wr_en. They are visible from the next cycle.
- Read latency is 1 cycle: rd_en sampled at edge N gives rd_valid=1 with rd_data/rd_oob after edge N.
- rd_valid is a single-cycle pulse per request. Back-to-back reads are supported, one per cycle.
- When rd_en is low, rd_valid drops to 0 and rd_data/rd_oob hold their last values.
- full is registered and consistent with count in every cycle.

## Configuration
- CHB_FREEZE_EN defined:
  - freeze port exists; while freeze=1, wr_en is ignored and wr_ptr, oldest_ptr, count and the array hold.
  - Reads operate normally on the frozen history. Releasing freeze resumes writing at wr_ptr.
  - Reset clears state regardless of freeze.
- CHB_FREEZE_EN undefined: no freeze port, and every wr_en is accepted.

## Test plan
Bench parameters: DEPTH=5, ADDR_W=3, DATA_W=12.
- Reset, then read rd_rel=0 -> rd_valid=1, rd_oob=1, rd_data=0, count=0, full=0.
- Write 0x101..0x103, then oldest-mode reads rel 0,1,2,3 -> 0x101, 0x102, 0x103, then oob. Newest-mode rel 0 -> 0x103.
- Write 0x101..0x107 (wrap) -> count=5, full=1, wr_ptr=2, oldest_ptr=2. Oldest rel 0 -> 0x103, rel 4 -> 0x107. Newest rel 4 -> 0x103. rel 5 and rel 7 -> oob.
- Full buffer with 0x103..0x107: write 0x108 with a simultaneous oldest rel 0 read -> read returns 0x103. The next oldest rel 0 read returns 0x104.
- Reset asserted mid-stream with wr_en=1 -> count=0, wr_ptr=0. The next write 0x1AA is read back as oldest rel 0.
- With CHB_FREEZE_EN: freeze=1 during writes 0x201..0x203 -> count and pointers unchanged, reads return the prior history. After freeze=0, writing 0x204 makes it newest rel 0.
